board_rst_seq_xilinx: RTL and testbench

BOARD_RST_SEQ_XILINX -- requirements
Module: board_rst_seq_xilinx

---
 rtl/board_rst_seq_pkg.sv | 22 ++
 rtl/board_rst_seq_xilinx_sync.sv | 40 ++++
 rtl/board_rst_seq_xilinx.sv | 197 +++++++++++++++++++
 tb/tb_board_rst_seq_xilinx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// board_rst_seq_pkg
// Shared types for the board reset sequencer: the sequencer state encoding
// and a helper that sizes counters from their terminal-count parameter.
// ----------------------------------------------------------------------------
package board_rst_seq_pkg;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        HOLD       = 2'd1,
        WAIT_CALIB = 2'd2,
        RUN        = 2'd3
    } rst_state_e;

    // Width of a counter that must reach n-1. A parameter of 1 still needs
    // a one-bit counter, because $clog2(1) is 0.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/board_rst_seq_xilinx_sync.sv
// ----------------------------------------------------------------------------
// board_rst_seq_xilinx_sync
// Single-bit common_cells-style synchronizer: a chain of Stages flops that
// brings an asynchronous input into the clk_i domain.
//
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears every stage
//   d_i    - asynchronous input bit
//   q_o    - synchronized output (last stage)
// ----------------------------------------------------------------------------
module board_rst_seq_xilinx_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // NOTE: every flop is reset, including this shift chain; after reset the
    // sequencer must see "no lock" rather than whatever the chain powered up to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its predecessor, so the loop order does not matter.
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/board_rst_seq_xilinx.sv
// ----------------------------------------------------------------------------
// board_rst_seq_xilinx
// Board-level reset sequencer. Holds the DRAM controller and the SoC in reset
// until the clock wizard is locked, keeps the DRAM reset asserted for
// HoldCycles after lock, optionally waits for DRAM calibration (with timeout
// and retry), then releases the SoC and latches the boot switches.
//
// Build option:
//   RSTSEQ_CALIB_WAIT_EN - when defined, the WAIT_CALIB state is implemented.
//                          When undefined, HOLD goes straight to RUN,
//                          calib_done_i is ignored and calib_timeout_o is 0.
//
// Ports:
//   clk_i           - free-running board clock (sole clock)
//   rst_i           - asynchronous active-high reset
//   pll_locked_i    - clock-wizard lock (asynchronous, synchronized here)
//   calib_done_i    - DRAM calibration complete (asynchronous, synchronized)
//   sw_rst_req_i    - software/VIO reset request, clk_i-synchronous level
//   boot_mode_i     - board boot switches (asynchronous, synchronized)
//   dram_rst_o      - DRAM controller reset, active-high
//   soc_rst_no      - SoC reset, active-low
//   boot_mode_o     - boot mode captured when the SoC is released
//   state_o         - current sequencer state
//   calib_timeout_o - sticky: a calibration timeout has occurred
// ----------------------------------------------------------------------------
module board_rst_seq_xilinx
    import board_rst_seq_pkg::*;
#(
    parameter int unsigned HoldCycles   = 1024,
    parameter int unsigned CalibTimeout = 2**20,
    parameter int unsigned SyncStages   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       calib_done_i,
    input  logic       sw_rst_req_i,
    input  logic [1:0] boot_mode_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic [1:0] state_o,
    output logic       calib_timeout_o
);

    localparam int unsigned HoldW = cnt_width(HoldCycles);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    // ------------------------------------------------------------------
    // Input synchronizers, one per asynchronous bit
    // ------------------------------------------------------------------
    logic       lock_s;
    logic [1:0] boot_s;

    board_rst_seq_xilinx_sync #(.Stages(SyncStages)) u_sync_lock (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    for (genvar b = 0; b < 2; b++) begin : g_sync_boot
        board_rst_seq_xilinx_sync #(.Stages(SyncStages)) u_sync_boot (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (boot_mode_i[b]),
            .q_o   (boot_s[b])
        );
    end

`ifdef RSTSEQ_CALIB_WAIT_EN
    localparam int unsigned CalibW = cnt_width(CalibTimeout);
    localparam logic [CalibW-1:0] CalibLast = CalibW'(CalibTimeout - 1);

    logic              calib_s;
    logic [CalibW-1:0] calib_cnt_q, calib_cnt_d;
    logic              timeout_q, timeout_d;

    board_rst_seq_xilinx_sync #(.Stages(SyncStages)) u_sync_calib (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (calib_done_i),
        .q_o   (calib_s)
    );
`else
    // Calibration handshake is not part of this build.
    logic unused_calib_done;
    assign unused_calib_done = calib_done_i;
`endif

    // ------------------------------------------------------------------
    // Sequencer state and counters
    // ------------------------------------------------------------------
    rst_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             dram_rst_q;
    logic             soc_rst_nq;
    logic [1:0]       boot_mode_q;

    always_comb begin
        // NOTE: every signal this block writes gets a default first, so no
        // path through the case statements can infer a latch.
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
`ifdef RSTSEQ_CALIB_WAIT_EN
        calib_cnt_d = calib_cnt_q;
        timeout_d   = timeout_q;
`endif

        if (!lock_s) begin
            // Losing lock beats everything, including a software request.
            state_d = WAIT_LOCK;
        end else if (sw_rst_req_i && (state_q != WAIT_LOCK)) begin
            // Held request keeps restarting the hold window.
            state_d    = HOLD;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
                HOLD: begin
                    if (hold_cnt_q == HoldLast) begin
`ifdef RSTSEQ_CALIB_WAIT_EN
                        state_d     = WAIT_CALIB;
                        calib_cnt_d = '0;
`else
                        state_d = RUN;
`endif
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
`ifdef RSTSEQ_CALIB_WAIT_EN
                WAIT_CALIB: begin
                    if (calib_s) begin
                        state_d = RUN;
                    end else if (calib_cnt_q == CalibLast) begin
                        // Retry: go back and pulse the DRAM reset again.
                        timeout_d  = 1'b1;
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        calib_cnt_d = calib_cnt_q + CalibW'(1);
                    end
                end
`endif
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    // Reset outputs come from their own flops, loaded from the next state,
    // so they change on the same edge as state_q and never glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WAIT_LOCK;
            hold_cnt_q  <= '0;
            dram_rst_q  <= 1'b1;
            soc_rst_nq  <= 1'b0;
            boot_mode_q <= 2'b00;
`ifdef RSTSEQ_CALIB_WAIT_EN
            calib_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dram_rst_q <= (state_d == WAIT_LOCK) || (state_d == HOLD);
            soc_rst_nq <= (state_d == RUN);
            if ((state_d == RUN) && (state_q != RUN)) begin
                boot_mode_q <= boot_s;
            end
`ifdef RSTSEQ_CALIB_WAIT_EN
            calib_cnt_q <= calib_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign dram_rst_o  = dram_rst_q;
    assign soc_rst_no  = soc_rst_nq;
    assign boot_mode_o = boot_mode_q;
    assign state_o     = state_q;
`ifdef RSTSEQ_CALIB_WAIT_EN
    assign calib_timeout_o = timeout_q;
`else
    assign calib_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_board_rst_seq_xilinx.sv
// ----------------------------------------------------------------------------
// tb_board_rst_seq_xilinx
// Self-checking bench for board_rst_seq_xilinx with HoldCycles=16,
// CalibTimeout=64, SyncStages=2. Expected latencies are computed from the
// sequencer's rules: an asynchronous input change reaches the state register
// SyncStages+1 edges after it is driven, a synchronous one after one edge,
// and HOLD lasts HoldCycles edges after its last (re)start.
// Honours RSTSEQ_CALIB_WAIT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_board_rst_seq_xilinx;

    localparam int HOLD_N  = 16;
    localparam int CALIB_N = 64;
    localparam int SYNC_N  = 2;
    localparam int ASYNC_LAT = SYNC_N + 1;

    localparam logic [1:0] S_WL   = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_WC   = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

`ifdef RSTSEQ_CALIB_WAIT_EN
    localparam logic [1:0] S_AFTER_HOLD = S_WC;
    localparam int         CALIB_EXTRA  = 1;  // WAIT_CALIB -> RUN when calib already synced
`else
    localparam logic [1:0] S_AFTER_HOLD = S_RUN;
    localparam int         CALIB_EXTRA  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       calib_done;
    logic       sw_rst_req;
    logic [1:0] boot_mode_in;
    logic       dram_rst;
    logic       soc_rst_n;
    logic [1:0] boot_mode_out;
    logic [1:0] state;
    logic       calib_timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    logic saw_state2 = 1'b0;

    board_rst_seq_xilinx #(
        .HoldCycles   (HOLD_N),
        .CalibTimeout (CALIB_N),
        .SyncStages   (SYNC_N)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pll_locked_i    (pll_locked),
        .calib_done_i    (calib_done),
        .sw_rst_req_i    (sw_rst_req),
        .boot_mode_i     (boot_mode_in),
        .dram_rst_o      (dram_rst),
        .soc_rst_no      (soc_rst_n),
        .boot_mode_o     (boot_mode_out),
        .state_o         (state),
        .calib_timeout_o (calib_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (state === 2'd2) saw_state2 <= 1'b1;
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until state_o shows target; n = -1 if the budget runs out.
    task automatic wait_state(input logic [1:0] target, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (state === target) begin
                n = i;
                break;
            end
        end
    endtask

    // Full reset, then bring-up with lock (and calib) already high.
    task automatic reach_run(input logic [1:0] bm);
        int n;
        rst = 1'b1; pll_locked = 1'b1; calib_done = 1'b1; sw_rst_req = 1'b0;
        boot_mode_in = bm;
        tick();
        rst = 1'b0;
        wait_state(S_RUN, 100, n);
        n_checks++;
        if (n !== ASYNC_LAT + HOLD_N + CALIB_EXTRA) begin
            n_errors++;
            $display("FAIL reach_run latency: got %0d, expected %0d", n, ASYNC_LAT + HOLD_N + CALIB_EXTRA);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; calib_done = 1'b1; sw_rst_req = 1'b0;
        boot_mode_in = 2'($urandom);
        repeat (4) tick();
        n_checks++;
        if (state !== S_WL) begin n_errors++; $display("FAIL reset state: got %0d, expected %0d", state, S_WL); end
        n_checks++;
        if (dram_rst !== 1'b1) begin n_errors++; $display("FAIL reset dram_rst: got %b, expected 1", dram_rst); end
        n_checks++;
        if (soc_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset soc_rst_n: got %b, expected 0", soc_rst_n); end
        n_checks++;
        if (boot_mode_out !== 2'b00) begin n_errors++; $display("FAIL reset boot_mode: got %b, expected 00", boot_mode_out); end
        n_checks++;
        if (calib_timeout !== 1'b0) begin n_errors++; $display("FAIL reset timeout: got %b, expected 0", calib_timeout); end
    endtask

    task automatic test_power_up();
        int n;
        rst = 1'b1; pll_locked = 1'b0; calib_done = 1'b0; sw_rst_req = 1'b0;
        boot_mode_in = 2'b10;
        tick();
        rst = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        n_checks++;
        if (state !== S_WL) begin n_errors++; $display("FAIL pre-lock state: got %0d, expected %0d", state, S_WL); end
        pll_locked = 1'b1;
        wait_state(S_HOLD, 20, n);
        n_checks++;
        if (n !== ASYNC_LAT) begin n_errors++; $display("FAIL lock->HOLD latency: got %0d, expected %0d", n, ASYNC_LAT); end
        n_checks++;
        if (dram_rst !== 1'b1 || soc_rst_n !== 1'b0) begin
            n_errors++; $display("FAIL HOLD resets: got dram=%b soc_n=%b, expected 1/0", dram_rst, soc_rst_n);
        end
        wait_state(S_AFTER_HOLD, 40, n);
        n_checks++;
        if (n !== HOLD_N) begin n_errors++; $display("FAIL HOLD length: got %0d, expected %0d", n, HOLD_N); end
        n_checks++;
        if (dram_rst !== 1'b0) begin n_errors++; $display("FAIL dram_rst release: got %b, expected 0", dram_rst); end
`ifdef RSTSEQ_CALIB_WAIT_EN
        n_checks++;
        if (soc_rst_n !== 1'b0) begin n_errors++; $display("FAIL WAIT_CALIB soc_rst_n: got %b, expected 0", soc_rst_n); end
        // calib_done rises 30 cycles after lock was driven.
        repeat (30 - ASYNC_LAT - HOLD_N) tick();
        calib_done = 1'b1;
        wait_state(S_RUN, 10, n);
        n_checks++;
        if (n !== ASYNC_LAT) begin n_errors++; $display("FAIL calib->RUN latency: got %0d, expected %0d", n, ASYNC_LAT); end
        n_checks++;
        if (calib_timeout !== 1'b0) begin n_errors++; $display("FAIL early timeout: got %b, expected 0", calib_timeout); end
`endif
        n_checks++;
        if (soc_rst_n !== 1'b1) begin n_errors++; $display("FAIL RUN soc_rst_n: got %b, expected 1", soc_rst_n); end
        n_checks++;
        if (boot_mode_out !== 2'b10) begin n_errors++; $display("FAIL boot latch at RUN: got %b, expected 10", boot_mode_out); end
    endtask

    task automatic test_boot_latch();
        boot_mode_in = 2'b01;
        repeat (8) tick();
        n_checks++;
        if (boot_mode_out !== 2'b10) begin n_errors++; $display("FAIL boot hold in RUN: got %b, expected 10", boot_mode_out); end
        n_checks++;
        if (state !== S_RUN) begin n_errors++; $display("FAIL still RUN: got %0d, expected %0d", state, S_RUN); end
    endtask

    // From RUN: software request for len cycles, with a new boot mode applied first.
    task automatic test_sw_req(input int len);
        int n;
        logic [1:0] bm;
        bm = 2'($urandom);
        boot_mode_in = bm;
        repeat (ASYNC_LAT) tick();
        sw_rst_req = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            n_checks++;
            if (state !== S_HOLD || dram_rst !== 1'b1) begin
                n_errors++; $display("FAIL sw_req HOLD: got state=%0d dram=%b, expected %0d/1", state, dram_rst, S_HOLD);
            end
        end
        sw_rst_req = 1'b0;
        wait_state(S_AFTER_HOLD, 40, n);
        n_checks++;
        if (len + n !== len + HOLD_N) begin n_errors++; $display("FAIL sw_req total HOLD: got %0d, expected %0d", len + n, len + HOLD_N); end
`ifdef RSTSEQ_CALIB_WAIT_EN
        wait_state(S_RUN, 5, n);
        n_checks++;
        if (n !== 1) begin n_errors++; $display("FAIL sw_req WAIT_CALIB->RUN: got %0d, expected 1", n); end
`endif
        n_checks++;
        if (boot_mode_out !== bm || soc_rst_n !== 1'b1) begin
            n_errors++; $display("FAIL sw_req relatch: got boot=%b soc_n=%b, expected %b/1", boot_mode_out, soc_rst_n, bm);
        end
    endtask

    // From RUN: drop lock for d cycles then restore it.
    task automatic test_lock_glitch(input int d);
        int n;
        pll_locked = 1'b0;
        repeat (d) tick();
        pll_locked = 1'b1;
        wait_state(S_HOLD, 20, n);
        n_checks++;
        if (d + n !== d + ASYNC_LAT) begin n_errors++; $display("FAIL lock glitch HOLD: got %0d, expected %0d", d + n, d + ASYNC_LAT); end
        wait_state(S_RUN, 40, n);
        n_checks++;
        if (n !== HOLD_N + CALIB_EXTRA) begin n_errors++; $display("FAIL lock glitch RUN: got %0d, expected %0d", n, HOLD_N + CALIB_EXTRA); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        wait_state(S_WL, 10, n);
        n_checks++;
        if (n !== ASYNC_LAT) begin n_errors++; $display("FAIL lock loss latency: got %0d, expected %0d", n, ASYNC_LAT); end
        n_checks++;
        if (soc_rst_n !== 1'b0 || dram_rst !== 1'b1) begin
            n_errors++; $display("FAIL lock loss resets: got soc_n=%b dram=%b, expected 0/1", soc_rst_n, dram_rst);
        end
        sw_rst_req = 1'b1;  // must not pull WAIT_LOCK into HOLD
        repeat (4) tick();
        sw_rst_req = 1'b0;
        n_checks++;
        if (state !== S_WL) begin n_errors++; $display("FAIL stay WAIT_LOCK: got %0d, expected %0d", state, S_WL); end
        test_lock_glitch(1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 0) test_sw_req($urandom_range(1, 8));
            else                           test_lock_glitch($urandom_range(1, 6));
        end
    endtask

`ifdef RSTSEQ_CALIB_WAIT_EN
    task automatic test_timeout();
        int n;
        rst = 1'b1; pll_locked = 1'b1; calib_done = 1'b0; sw_rst_req = 1'b0;
        tick();
        rst = 1'b0;
        wait_state(S_WC, 40, n);
        n_checks++;
        if (n !== ASYNC_LAT + HOLD_N) begin n_errors++; $display("FAIL to WAIT_CALIB: got %0d, expected %0d", n, ASYNC_LAT + HOLD_N); end
        wait_state(S_HOLD, CALIB_N + 20, n);
        n_checks++;
        if (n !== CALIB_N) begin n_errors++; $display("FAIL timeout cycle: got %0d, expected %0d", n, CALIB_N); end
        n_checks++;
        if (calib_timeout !== 1'b1 || dram_rst !== 1'b1) begin
            n_errors++; $display("FAIL timeout flags: got to=%b dram=%b, expected 1/1", calib_timeout, dram_rst);
        end
        calib_done = 1'b1;
        wait_state(S_RUN, 40, n);
        n_checks++;
        if (n !== HOLD_N + 1) begin n_errors++; $display("FAIL retry RUN: got %0d, expected %0d", n, HOLD_N + 1); end
        n_checks++;
        if (calib_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout sticky: got %b, expected 1", calib_timeout); end
    endtask
`endif

    task automatic test_rst_mid();
        int n;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (state !== S_WL || dram_rst !== 1'b1 || soc_rst_n !== 1'b0) begin
            n_errors++; $display("FAIL async reset: got state=%0d dram=%b soc_n=%b, expected 0/1/0", state, dram_rst, soc_rst_n);
        end
        n_checks++;
        if (calib_timeout !== 1'b0 || boot_mode_out !== 2'b00) begin
            n_errors++; $display("FAIL async reset clears: got to=%b boot=%b, expected 0/00", calib_timeout, boot_mode_out);
        end
        tick();
        rst = 1'b0;
        wait_state(S_HOLD, 10, n);
        n_checks++;
        if (n !== ASYNC_LAT) begin n_errors++; $display("FAIL restart after reset: got %0d, expected %0d", n, ASYNC_LAT); end
    endtask

`ifndef RSTSEQ_CALIB_WAIT_EN
    task automatic test_no_calib();
        int n;
        rst = 1'b1; pll_locked = 1'b0; calib_done = 1'b0; sw_rst_req = 1'b0;
        tick();
        rst = 1'b0;
        pll_locked = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            calib_done = 1'($urandom);
            tick();
            if (state === S_RUN) begin n = i; break; end
        end
        n_checks++;
        if (n !== ASYNC_LAT + HOLD_N) begin n_errors++; $display("FAIL no-calib RUN: got %0d, expected %0d", n, ASYNC_LAT + HOLD_N); end
        n_checks++;
        if (calib_timeout !== 1'b0) begin n_errors++; $display("FAIL no-calib timeout: got %b, expected 0", calib_timeout); end
        n_checks++;
        if (saw_state2 !== 1'b0) begin n_errors++; $display("FAIL state 2 seen: got %b, expected 0", saw_state2); end
    endtask
`endif

    initial begin
        rst = 1'b1; pll_locked = 1'b0; calib_done = 1'b0; sw_rst_req = 1'b0; boot_mode_in = 2'b00;
        test_reset();
        test_power_up();
        test_boot_latch();
        test_sw_req(5);
        test_lock_loss();
        test_random();
`ifdef RSTSEQ_CALIB_WAIT_EN
        test_timeout();
`endif
        test_rst_mid();
        reach_run(2'($urandom));
        test_sw_req($urandom_range(1, 8));
`ifndef RSTSEQ_CALIB_WAIT_EN
        test_no_calib();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
